// File: rtl/serial_compare_ctrl_if.sv
// Operand/result bundle for serial_compare_ctrl: operand pair in, compare flags out.
// master = producer/consumer side, slave = the comparator controller.
interface serial_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic             a_eq_b;
    logic             a_gt_b;
    logic             a_lt_b;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, a_eq_b, a_gt_b, a_lt_b
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, a_eq_b, a_gt_b, a_lt_b
    );
endinterface

// File: rtl/serial_compare_ctrl.sv
// MSB-first serial magnitude comparator, one 2-bit slice per clock through a shared slice compare.
// Optional SERIAL_CMP_EARLY_EXIT_EN: finish on the first differing slice instead of a full scan.
module serial_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_compare_ctrl_if.slave bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE and the flags hold
    // steady there until out_ready is seen.

    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IW-1:0]    idx;
    logic             dec_gt;
    logic             dec_lt;
    logic             res_eq;
    logic             res_gt;
    logic             res_lt;

    logic [1:0]       sl_a;
    logic [1:0]       sl_b;
    logic             undecided;
    logic             nxt_gt;
    logic             nxt_lt;
    logic             last_slice;
    logic             run_exit;
    logic             accept;

    // Shared slice compare: select the current slice of each operand by idx.
    always_comb begin
        sl_a = 2'b00;
        sl_b = 2'b00;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                sl_a = op_a[2*i +: 2];
                sl_b = op_b[2*i +: 2];
            end
        end
    end

    // A decision, once recorded, is sticky: later slices only matter while undecided.
    assign undecided  = !(dec_gt || dec_lt);
    assign nxt_gt     = dec_gt || (undecided && (sl_a > sl_b));
    assign nxt_lt     = dec_lt || (undecided && (sl_a < sl_b));
    assign last_slice = (idx == '0);
    assign accept     = bus.in_valid && (state == IDLE);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign run_exit = last_slice || nxt_gt || nxt_lt;
`else
    assign run_exit = last_slice;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)        state_nxt = RUN;
            RUN:  if (run_exit)      state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.a_eq_b    = res_eq;
        bus.a_gt_b    = res_gt;
        bus.a_lt_b    = res_lt;
        busy          = (state != IDLE);
        state_dbg     = state;
    end

    // Operand, slice index, decision and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            idx    <= '0;
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
            res_eq <= 1'b0;
            res_gt <= 1'b0;
            res_lt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= bus.a_in;
                        op_b   <= bus.b_in;
                        idx    <= IW'(N - 1);
                        dec_gt <= 1'b0;
                        dec_lt <= 1'b0;
                        res_eq <= 1'b0;
                        res_gt <= 1'b0;
                        res_lt <= 1'b0;
                    end
                end
                RUN: begin
                    dec_gt <= nxt_gt;
                    dec_lt <= nxt_lt;
                    // Flags take the decision including one made on this final slice.
                    if (run_exit) begin
                        res_gt <= nxt_gt;
                        res_lt <= nxt_lt;
                        res_eq <= !(nxt_gt || nxt_lt);
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        res_eq <= 1'b0;
                        res_gt <= 1'b0;
                        res_lt <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed and randomized checks of serial_compare_ctrl at WIDTH 8, 2 and 16.
// Inputs change on the falling edge or 1 time unit after the rising edge; outputs sampled 1 unit after it.
module tb_serial_compare_ctrl;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] f;   // {eq, gt, lt}
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  logic       busy8, busy2, busy16;
  logic [1:0] st8, st2, st16;

  serial_compare_ctrl_if #(.WIDTH(8))  if8 ();
  serial_compare_ctrl_if #(.WIDTH(2))  if2 ();
  serial_compare_ctrl_if #(.WIDTH(16)) if16 ();

  serial_compare_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8.slave),  .busy(busy8),  .state_dbg(st8));
  serial_compare_ctrl #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(if2.slave),  .busy(busy2),  .state_dbg(st2));
  serial_compare_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16.slave), .busy(busy16), .state_dbg(st16));

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks (WIDTH=8 instance)
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    if8.in_valid = 1'b1;
    if8.a_in = a;
    if8.b_in = b;
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (if8.out_valid) lat = k;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if8.in_valid = 0;  if8.out_ready = 0;  if8.a_in = 0;  if8.b_in = 0;
    if2.in_valid = 0;  if2.out_ready = 0;  if2.a_in = 0;  if2.b_in = 0;
    if16.in_valid = 0; if16.out_ready = 0; if16.a_in = 0; if16.b_in = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (if8.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b exp 1", if8.in_ready); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b exp 0", busy8); end
    total++; if (if8.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b exp 0", if8.out_valid); end
    total++; if ({if8.a_eq_b, if8.a_gt_b, if8.a_lt_b} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b exp 000", {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b}); end
    total++; if (st8 !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d exp 0", st8); end
    total++; if (if2.in_ready !== 1'b1 || if16.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_w2_w16: got %b%b exp 11", if2.in_ready, if16.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (if8.in_ready !== 1'b1 || busy8 !== 1'b0) begin bad++; $display("FAIL post_rst_idle: got ready=%b busy=%b exp ready=1 busy=0", if8.in_ready, busy8); end
  endtask

  task automatic test_directed;
    vec_t v[7];
    int   lat;
    v[0] = '{8'h5A, 8'h5A, 3'b100, 4};
    v[1] = '{8'h80, 8'h7F, 3'b010, EE ? 1 : 4};
    v[2] = '{8'h12, 8'h13, 3'b001, 4};
    v[3] = '{8'h40, 8'h3F, 3'b010, EE ? 1 : 4};  // later slices favour B: decision must stick
    v[4] = '{8'h08, 8'h0C, 3'b001, EE ? 3 : 4};
    v[5] = '{8'h00, 8'hFF, 3'b001, EE ? 1 : 4};
    v[6] = '{8'hFF, 8'hFF, 3'b100, 4};
    for (int i = 0; i < 7; i++) begin
      total++; if (if8.in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_ready_before: got %b exp 1", i, if8.in_ready); end
      start_op8(v[i].a, v[i].b);
      total++; if (busy8 !== 1'b1 || if8.in_ready !== 1'b0 || if8.out_valid !== 1'b0) begin
        bad++; $display("FAIL dir%0d_run: got busy=%b ready=%b ov=%b exp 1 0 0", i, busy8, if8.in_ready, if8.out_valid);
      end
      wait_done8(lat);
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL dir%0d_latency: got %0d exp %0d", i, lat, v[i].lat); end
      total++; if ({if8.a_eq_b, if8.a_gt_b, if8.a_lt_b} !== v[i].f) begin
        bad++; $display("FAIL dir%0d_flags: got %b exp %b", i, {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b}, v[i].f);
      end
      @(negedge clk);
      if8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      total++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1 || {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b} !== 3'b000) begin
        bad++; $display("FAIL dir%0d_release: got ov=%b ready=%b flags=%b exp 0 1 000", i, if8.out_valid, if8.in_ready, {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b});
      end
      @(negedge clk);
      if8.out_ready = 1'b0;
    end
  endtask

  task automatic test_hold;
    int lat;
    start_op8(8'h80, 8'h7F);
    wait_done8(lat);
    total++; if (lat !== (EE ? 1 : 4)) begin bad++; $display("FAIL hold_latency: got %0d exp %0d", lat, EE ? 1 : 4); end
    @(negedge clk);
    if8.in_valid = 1'b1;
    if8.a_in = 8'h00;
    if8.b_in = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      total++; if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0 || {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b} !== 3'b010) begin
        bad++; $display("FAIL hold_cycle%0d: got ov=%b ready=%b flags=%b exp 1 0 010", k, if8.out_valid, if8.in_ready, {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b});
      end
    end
    @(negedge clk);
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (if8.out_valid !== 1'b0 || st8 !== 2'd0 || {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b} !== 3'b000) begin
      bad++; $display("FAIL hold_release: got ov=%b state=%0d flags=%b exp 0 0 000", if8.out_valid, st8, {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b});
    end
    @(negedge clk);
    if8.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL hold_ignored_operands: got busy=%b exp 0", busy8); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    start_op8(8'h01, 8'h02);
    @(posedge clk);
    #1;
    total++; if (st8 !== 2'd1) begin bad++; $display("FAIL midrst_in_run: got state=%0d exp 1", st8); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1 || busy8 !== 1'b0 || {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b} !== 3'b000) begin
      bad++; $display("FAIL midrst_abort: got ov=%b ready=%b busy=%b flags=%b exp 0 1 0 000", if8.out_valid, if8.in_ready, busy8, {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (if8.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_pulse: got ov=%b exp 0", if8.out_valid); end
    start_op8(8'hFF, 8'h00);
    wait_done8(lat);
    total++; if (lat !== (EE ? 1 : 4)) begin bad++; $display("FAIL midrst_next_latency: got %0d exp %0d", lat, EE ? 1 : 4); end
    total++; if ({if8.a_eq_b, if8.a_gt_b, if8.a_lt_b} !== 3'b010) begin bad++; $display("FAIL midrst_next_flags: got %b exp 010", {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b}); end
    @(negedge clk);
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    if8.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    if8.out_ready = 1'b1;
    start_op8(8'h33, 8'h22);
    wait_done8(lat);
    total++; if (lat !== (EE ? 2 : 4)) begin bad++; $display("FAIL b2b0_latency: got %0d exp %0d", lat, EE ? 2 : 4); end
    total++; if ({if8.a_eq_b, if8.a_gt_b, if8.a_lt_b} !== 3'b010) begin bad++; $display("FAIL b2b0_flags: got %b exp 010", {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b}); end
    @(posedge clk);
    #1;
    total++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin bad++; $display("FAIL b2b0_one_cycle: got ov=%b ready=%b exp 0 1", if8.out_valid, if8.in_ready); end
    start_op8(8'h22, 8'h33);
    wait_done8(lat);
    total++; if (lat !== (EE ? 2 : 4)) begin bad++; $display("FAIL b2b1_latency: got %0d exp %0d", lat, EE ? 2 : 4); end
    total++; if ({if8.a_eq_b, if8.a_gt_b, if8.a_lt_b} !== 3'b001) begin bad++; $display("FAIL b2b1_flags: got %b exp 001", {if8.a_eq_b, if8.a_gt_b, if8.a_lt_b}); end
    @(posedge clk);
    #1;
    total++; if (if8.out_valid !== 1'b0) begin bad++; $display("FAIL b2b1_one_cycle: got ov=%b exp 0", if8.out_valid); end
    @(negedge clk);
    if8.out_ready = 1'b0;
  endtask

  task automatic test_width2;
    int         lat;
    logic [2:0] exp_f;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        exp_f = {a == b, a > b, a < b};
        @(negedge clk);
        if2.in_valid = 1'b1;
        if2.a_in = 2'(a);
        if2.b_in = 2'(b);
        @(posedge clk);
        #1;
        if2.in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
          @(posedge clk);
          #1;
          if (if2.out_valid) lat = k;
        end
        total++; if (lat !== 1) begin bad++; $display("FAIL w2_%0d_%0d_latency: got %0d exp 1", a, b, lat); end
        total++; if ({if2.a_eq_b, if2.a_gt_b, if2.a_lt_b} !== exp_f) begin
          bad++; $display("FAIL w2_%0d_%0d_flags: got %b exp %b", a, b, {if2.a_eq_b, if2.a_gt_b, if2.a_lt_b}, exp_f);
        end
        @(negedge clk);
        if2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        if2.out_ready = 1'b0;
      end
    end
  endtask

  task automatic test_random_w16;
    logic [2:0] exp_q[$];
    logic [2:0] exp_f;
    logic [2:0] got_f;
    int         sent;
    int         got;
    int         guard;
    int         wait_cnt;
    logic [15:0] a;
    logic [15:0] b;
    sent = 0;
    got = 0;
    guard = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if16.in_valid = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 16'($urandom_range(0, 65535));
          case ($urandom_range(0, 3))
            0: b = a;
            1: b = a ^ 16'($urandom_range(1, 3));   // differs only in the last slice
            default: b = 16'($urandom_range(0, 65535));
          endcase
          if16.in_valid = 1'b1;
          if16.a_in = a;
          if16.b_in = b;
          wait_cnt = 0;
          while (!if16.in_ready && wait_cnt < 1000) begin
            @(negedge clk);
            wait_cnt++;
          end
          exp_f = {a == b, a > b, a < b};
          exp_q.push_back(exp_f);
          sent++;
          @(posedge clk);
        end
        @(negedge clk);
        if16.in_valid = 1'b0;
      end
      begin
        while (got < 1000 && guard < 60000) begin
          @(negedge clk);
          guard++;
          if16.out_ready = 1'($urandom_range(0, 1));
          if (if16.out_valid && if16.out_ready) begin
            got_f = {if16.a_eq_b, if16.a_gt_b, if16.a_lt_b};
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL w16_extra_result: got %b exp none", got_f);
            end else begin
              exp_f = exp_q.pop_front();
              if (got_f !== exp_f) begin bad++; $display("FAIL w16_result%0d: got %b exp %b", got, got_f, exp_f); end
            end
            total++; if ($countones(got_f) != 1) begin bad++; $display("FAIL w16_onehot%0d: got %b exp one flag", got, got_f); end
            got++;
          end
        end
        if16.out_ready = 1'b0;
      end
    join
    total++; if (got != 1000 || sent != 1000) begin bad++; $display("FAIL w16_count: got %0d/%0d exp 1000/1000", got, sent); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL w16_leftover: got %0d exp 0", exp_q.size()); end
  endtask

  // final report
  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    test_width2();
    test_random_w16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
